// File: rtl/packet_mux_arbiter_pkg.sv
// packet_mux_arbiter_pkg
//   Shared types and helpers for the packet mux arbiter.
//   arb_state_t : ARB (free to pick a new requester) / LOCKED (holding a packet)
//   id_width()  : width of a requester index for a given requester count
package packet_mux_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packet_mux_arbiter_rr_pick.sv
// rr_pick
//   Combinational circular priority encoder. Returns the first set bit of
//   valid, searching ptr, ptr+1, ... and wrapping past N_REQ-1 to 0.
//   valid [N_REQ] : candidate vector
//   ptr   [IW]    : index where the search starts (0..N_REQ-1)
//   any   [1]     : at least one candidate is set
//   g     [IW]    : winning index (equals ptr when any is low)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    g
);

    // One extra bit so ptr + k (at most 2*N_REQ-2) cannot overflow before the wrap.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(k);
        if (s >= (IW+1)'(N_REQ)) begin
            s = s - (IW+1)'(N_REQ);
        end
        return s[IW-1:0];
    endfunction

    // Walk from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        any = |valid;
        g   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid[wrap_idx(ptr, k)]) begin
                g = wrap_idx(ptr, k);
            end
        end
    end

endmodule

// File: rtl/packet_mux_arbiter.sv
// packet_mux_arbiter
//   Round-robin arbiter sharing one N:1 data mux and one registered output
//   channel among N_REQ valid/ready requesters. A multi-beat packet keeps the
//   grant until its last beat is accepted.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/last [N_REQ]: per-requester beat valid / final-beat flag
//   req_data [N_REQ*W]    : requester i at [i*W +: W]
//   req_ready [N_REQ]     : one-hot accept strobe (combinational)
//   out_valid/data/last/id: registered output beat and its source
//   out_ready             : consumer accepts when out_valid is high
module packet_mux_arbiter
    import packet_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*W-1:0]           req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    output logic [W-1:0]                 out_data,
    output logic                         out_last,
    output logic [id_width(N_REQ)-1:0]   out_id,
    input  logic                         out_ready
);

    localparam int IW = id_width(N_REQ);

    arb_state_t    state, next_state;
    logic [IW-1:0] owner, next_owner;
    logic [IW-1:0] ptr, next_ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] g;
    logic          any;
    logic          load;
    logic          accept;
    logic [W-1:0]  sel_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .any   (any),
        .g     (g)
    );

    // Output register is empty or being drained this cycle.
    assign load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= next_state;
            owner <= next_owner;
            ptr   <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_owner = owner;
        next_ptr   = ptr;
        accept     = 1'b0;
        sel        = g;
        unique case (state)
            ARB: begin
                if (load && any) begin
                    accept = 1'b1;
                    if (req_last[g]) begin
                        next_ptr = next_idx(g);
                    end else begin
                        next_state = LOCKED;
                        next_owner = g;
                    end
                end
            end
            LOCKED: begin
                // Owner keeps the channel even while idle; others wait.
                sel = owner;
                if (load && req_valid[owner]) begin
                    accept = 1'b1;
                    if (req_last[owner]) begin
                        next_state = ARB;
                        next_ptr   = next_idx(owner);
                    end
                end
            end
            default: ;
        endcase
    end

    // Gated by rst_n so nothing is handshaken while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign sel_data = req_data[int'(sel) * W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= req_last[sel];
            out_id    <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_mux_arbiter.sv
module tb_packet_mux_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [IW-1:0]   out_id;
    logic            out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the channel is either free or owned; ptr is where the
    // next free-channel search begins.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [W-1:0] m_data;
    bit          m_last;
    int          m_id;
    logic [N-1:0] ready_s;

    packet_mux_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0;
        m_ov = 0; m_data = '0; m_last = 0; m_id = 0;
    endtask

    // One clock: checks req_ready before the edge, outputs after it.
    task automatic step();
        int grant;
        bit load;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        load = !m_ov || out_ready;
        grant = -1;
        if (!m_locked) begin
            int p;
            p = pick(req_valid, m_ptr);
            if (load && p >= 0) grant = p;
        end else if (load && req_valid[m_owner]) begin
            grant = m_owner;
        end
        exp_ready = '0;
        if (grant >= 0) exp_ready[grant] = 1'b1;
        ready_s = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (grant >= 0) begin
            m_ov = 1; m_data = req_data[grant*W +: W]; m_last = req_last[grant]; m_id = grant;
            if (req_last[grant]) begin
                m_locked = 0; m_ptr = (grant + 1) % N;
            end else begin
                m_locked = 1; m_owner = grant;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_last", 32'(out_last), 32'(m_last));
        check("out_id", 32'(out_id), 32'(m_id));
    endtask

    // Entered and left at posedge+1; reset edges fall between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_data_const();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h10 + i);
    endtask

    typedef struct {
        bit           rst_before;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic [N-1:0] exp_ready;
        logic [IW-1:0] exp_id;
    } vec_t;

    vec_t vecs[10];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness: all valid, single-beat, continuous drain.
        vecs[0] = '{1, 4'b1111, 4'b1111, 4'b0001, 2'd0};
        vecs[1] = '{0, 4'b1111, 4'b1111, 4'b0010, 2'd1};
        vecs[2] = '{0, 4'b1111, 4'b1111, 4'b0100, 2'd2};
        vecs[3] = '{0, 4'b1111, 4'b1111, 4'b1000, 2'd3};
        vecs[4] = '{0, 4'b1111, 4'b1111, 4'b0001, 2'd0};
        vecs[5] = '{0, 4'b1111, 4'b1111, 4'b0010, 2'd1};
        // Packet lock: req0 three beats while req1 waits.
        vecs[6] = '{1, 4'b0011, 4'b0010, 4'b0001, 2'd0};
        vecs[7] = '{0, 4'b0011, 4'b0010, 4'b0001, 2'd0};
        vecs[8] = '{0, 4'b0011, 4'b0011, 4'b0001, 2'd0};
        vecs[9] = '{0, 4'b0010, 4'b0010, 4'b0010, 2'd1};

        // Reset then idle.
        do_reset();
        req_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            check("idle_ready", 32'(ready_s), 32'd0);
            check("idle_out_valid", 32'(out_valid), 32'd0);
        end

        set_data_const();
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            step();
            check("vec_ready", 32'(ready_s), 32'(vecs[i].exp_ready));
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_out_id", 32'(out_id), 32'(vecs[i].exp_id));
            check("vec_out_data", 32'(out_data), 32'(8'h10 + vecs[i].exp_id));
        end

        // Backpressure: hold 0xA5 for five cycles, then drain.
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001; req_last = 4'b0001; req_data[0 +: W] = 8'hA5;
        step();
        req_data[0 +: W] = 8'h3C;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", 32'(ready_s), 32'd0);
            check("bp_data", 32'(out_data), 32'hA5);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_ready", 32'(ready_s), 32'b0001);
        check("bp_release_data", 32'(out_data), 32'h3C);

        // Skip and wrap: move ptr to 3, then only req1 and req3 valid.
        do_reset();
        set_data_const();
        out_ready = 1'b1;
        req_valid = 4'b0100; req_last = 4'b0100;
        step();
        req_valid = 4'b1010; req_last = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wrap_id", 32'(out_id), (i % 2 == 0) ? 32'd3 : 32'd1);
        end

        // Async reset after beat 2 of a 4-beat packet.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0000;
        step();
        step();
        check("mid_locked_valid", 32'(out_valid), 32'd1);
        req_valid = 4'b1101;
        do_reset();
        req_valid = 4'b1100; req_last = 4'b1100;
        step();
        check("after_rst_ready", 32'(ready_s), 32'b0100);
        check("after_rst_id", 32'(out_id), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) req_last[r] = ($urandom_range(0, 2) == 0);
            req_data  = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
